// File: rtl/glb_csb_bridge.sv
// ---------------------------------------------------------------------------
// glb_csb_bridge
// CSB-side front end of the GLB register/interrupt unit.
//
// Requests from the CSB master go through a 2-entry in-order FIFO and are
// then forwarded to GLB. Reads and non-posted writes are tracked as
// outstanding. GLB responses are registered back to the CSB master. If GLB
// stays silent too long, an error response is synthesized so that the CSB
// master can never deadlock.
//
// Ports
//   nvdla_core_clk      clock, rising edge
//   nvdla_core_rst      synchronous active-high reset
//   csb2glb_req_*       request channel from the CSB master (valid/ready, 63b)
//   glb_req_*           request channel to GLB (valid/ready, 63b)
//   glb_resp_*          single-cycle response from GLB (34b)
//   glb2csb_resp_*      single-cycle response to the CSB master (34b)
//   outstanding_cnt     issued requests still awaiting a response
//   timeout_err         one-cycle pulse per synthesized error response
//   stray_resp          sticky flag: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module glb_csb_bridge #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 1024
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        csb2glb_req_pvld,
    output logic        csb2glb_req_prdy,
    input  logic [62:0] csb2glb_req_pd,
    output logic        glb_req_pvld,
    input  logic        glb_req_prdy,
    output logic [62:0] glb_req_pd,
    input  logic        glb_resp_valid,
    input  logic [33:0] glb_resp_pd,
    output logic        glb2csb_resp_valid,
    output logic [33:0] glb2csb_resp_pd,
    output logic [3:0]  outstanding_cnt,
    output logic        timeout_err,
    output logic        stray_resp
);

    localparam int             TW        = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT - 1);
    localparam logic [3:0]     MAX_CNT   = 4'(MAX_OUTSTANDING);

    // A read, or a non-posted write, expects a response.
    function automatic logic needs_resp(input logic [62:0] pd);
        return (~pd[54]) | pd[55];
    endfunction

    // slot0 is always the FIFO head, so the head is driven straight from a flop.
    logic [62:0]                slot0_r, slot1_r, slot0_nxt_s, slot1_nxt_s;
    logic [1:0]                 fifo_cnt_r, fifo_cnt_nxt_s;
    logic                       prdy_r, pvld_r, pvld_nxt_s;
    logic [3:0]                 out_cnt_r, out_cnt_nxt_s;
    logic [MAX_OUTSTANDING-1:0] typeq_r, typeq_nxt_s;
    logic [31:0]                q_idx_s;
    logic [TW-1:0]              timer_r, timer_nxt_s;
    logic                       push_s, pop_s, issue_np_s;
    logic                       resp_acc_s, stray_s, tmo_s, dec_s;
    logic                       resp_valid_r, timeout_err_r, stray_r;
    logic [33:0]                resp_pd_r;

    assign push_s     = csb2glb_req_pvld & prdy_r;
    assign pop_s      = pvld_r & glb_req_prdy;
    assign issue_np_s = pop_s & needs_resp(slot0_r);
    assign resp_acc_s = glb_resp_valid & (out_cnt_r != 4'd0);
    assign stray_s    = glb_resp_valid & (out_cnt_r == 4'd0);
    // A real response in the same cycle always beats the timeout.
    assign tmo_s      = (~glb_resp_valid) & (out_cnt_r != 4'd0) & (timer_r == TIMER_MAX);
    assign dec_s      = resp_acc_s | tmo_s;

    // FIFO next state: shift-register organisation with the head in slot0.
    always_comb begin
        slot0_nxt_s    = slot0_r;
        slot1_nxt_s    = slot1_r;
        fifo_cnt_nxt_s = fifo_cnt_r;
        case (fifo_cnt_r)
            2'd0: begin
                if (push_s) begin
                    slot0_nxt_s    = csb2glb_req_pd;
                    fifo_cnt_nxt_s = 2'd1;
                end else begin
                    fifo_cnt_nxt_s = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    slot0_nxt_s    = csb2glb_req_pd;
                end else if (push_s) begin
                    slot1_nxt_s    = csb2glb_req_pd;
                    fifo_cnt_nxt_s = 2'd2;
                end else if (pop_s) begin
                    fifo_cnt_nxt_s = 2'd0;
                end else begin
                    fifo_cnt_nxt_s = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    slot0_nxt_s = slot1_r;
                    if (push_s) begin
                        slot1_nxt_s    = csb2glb_req_pd;
                        fifo_cnt_nxt_s = 2'd2;
                    end else begin
                        fifo_cnt_nxt_s = 2'd1;
                    end
                end else begin
                    fifo_cnt_nxt_s = 2'd2;
                end
            end
            default: begin
                fifo_cnt_nxt_s = 2'd0;
            end
        endcase
    end

    // Outstanding count, expected-type queue (occupancy == count) and timer.
    always_comb begin
        out_cnt_nxt_s = out_cnt_r + {3'd0, issue_np_s} - {3'd0, dec_s};
        q_idx_s       = {28'd0, out_cnt_r} - {31'd0, dec_s};
        if (dec_s) begin
            typeq_nxt_s = typeq_r >> 1'b1;
        end else begin
            typeq_nxt_s = typeq_r;
        end
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (issue_np_s && (q_idx_s == 32'(i))) begin
                typeq_nxt_s[i] = slot0_r[54];
            end else begin
                typeq_nxt_s[i] = typeq_nxt_s[i];
            end
        end
        if ((out_cnt_r == 4'd0) || glb_resp_valid || tmo_s) begin
            timer_nxt_s = '0;
        end else if (timer_r == TIMER_MAX) begin
            timer_nxt_s = timer_r;
        end else begin
            timer_nxt_s = timer_r + TW'(1);
        end
        // Issue gating evaluated on next state so glb_req_pvld can be a flop.
        pvld_nxt_s = (fifo_cnt_nxt_s != 2'd0) &
                     ((~needs_resp(slot0_nxt_s)) | (out_cnt_nxt_s < MAX_CNT));
    end

    // State and output registers.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            slot0_r       <= 63'd0;
            slot1_r       <= 63'd0;
            fifo_cnt_r    <= 2'd0;
            prdy_r        <= 1'b1;
            pvld_r        <= 1'b0;
            out_cnt_r     <= 4'd0;
            typeq_r       <= '0;
            timer_r       <= '0;
            resp_valid_r  <= 1'b0;
            resp_pd_r     <= 34'd0;
            timeout_err_r <= 1'b0;
            stray_r       <= 1'b0;
        end else begin
            slot0_r       <= slot0_nxt_s;
            slot1_r       <= slot1_nxt_s;
            fifo_cnt_r    <= fifo_cnt_nxt_s;
            prdy_r        <= (fifo_cnt_nxt_s != 2'd2);
            pvld_r        <= pvld_nxt_s;
            out_cnt_r     <= out_cnt_nxt_s;
            typeq_r       <= typeq_nxt_s;
            timer_r       <= timer_nxt_s;
            resp_valid_r  <= dec_s;
            timeout_err_r <= tmo_s;
            stray_r       <= stray_r | stray_s;
            if (resp_acc_s) begin
                resp_pd_r <= glb_resp_pd;
            end else if (tmo_s) begin
                resp_pd_r <= {typeq_r[0], 1'b1, 32'h0000_0000};
            end else begin
                resp_pd_r <= resp_pd_r;
            end
        end
    end

    assign csb2glb_req_prdy   = prdy_r;
    assign glb_req_pvld       = pvld_r;
    assign glb_req_pd         = slot0_r;
    assign glb2csb_resp_valid = resp_valid_r;
    assign glb2csb_resp_pd    = resp_pd_r;
    assign outstanding_cnt    = out_cnt_r;
    assign timeout_err        = timeout_err_r;
    assign stray_resp         = stray_r;

endmodule

// File: tb/tb_glb_csb_bridge.sv
// ---------------------------------------------------------------------------
// tb_glb_csb_bridge
// Directed bench for glb_csb_bridge (MAX_OUTSTANDING = 4, TIMEOUT = 16).
// A table of per-cycle stimulus/expected records covers the posted write,
// read round trip, outstanding limit and simultaneous issue/response. Hand
// sequences cover timeout, response-at-timeout and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_glb_csb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_pvld;
    logic        req_prdy;
    logic [62:0] req_pd;
    logic        g_pvld;
    logic        g_prdy;
    logic [62:0] g_pd;
    logic        r_valid;
    logic [33:0] r_pd;
    logic        o_valid;
    logic [33:0] o_pd;
    logic [3:0]  cnt;
    logic        terr;
    logic        stray;

    int total = 0;
    int bad   = 0;

    glb_csb_bridge #(.MAX_OUTSTANDING(4), .TIMEOUT(16)) dut (
        .nvdla_core_clk     (clk),
        .nvdla_core_rst     (rst),
        .csb2glb_req_pvld   (req_pvld),
        .csb2glb_req_prdy   (req_prdy),
        .csb2glb_req_pd     (req_pd),
        .glb_req_pvld       (g_pvld),
        .glb_req_prdy       (g_prdy),
        .glb_req_pd         (g_pd),
        .glb_resp_valid     (r_valid),
        .glb_resp_pd        (r_pd),
        .glb2csb_resp_valid (o_valid),
        .glb2csb_resp_pd    (o_pd),
        .outstanding_cnt    (cnt),
        .timeout_err        (terr),
        .stray_resp         (stray)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pvld;
        logic [62:0] pd;
        logic        rv;
        logic [33:0] rpd;
        logic        e_prdy;
        logic        e_gpvld;
        logic [62:0] e_gpd;
        logic [3:0]  e_cnt;
        logic        e_rv;
        logic [33:0] e_rpd;
    } vec_t;

    vec_t vt[26];

    function automatic logic [62:0] mk(input logic [21:0] a, input logic [31:0] d,
                                       input logic w, input logic np);
        return {2'b00, 4'hF, 1'b0, np, w, d, a};
    endfunction

    function automatic vec_t row(input logic pvld, input logic [62:0] pd,
                                 input logic rv, input logic [33:0] rpd,
                                 input logic e_prdy, input logic e_gpvld,
                                 input logic [62:0] e_gpd, input logic [3:0] e_cnt,
                                 input logic e_rv, input logic [33:0] e_rpd);
        vec_t v;
        v.pvld = pvld; v.pd = pd; v.rv = rv; v.rpd = rpd;
        v.e_prdy = e_prdy; v.e_gpvld = e_gpvld; v.e_gpd = e_gpd;
        v.e_cnt = e_cnt; v.e_rv = e_rv; v.e_rpd = e_rpd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [62:0] pw1, rd0, r1, r2, r3, r4, r5, pw2, npw;
    logic [33:0] z34;
    logic        seen;

    initial begin
        pw1 = mk(22'h20, 32'hDEAD_BEEF, 1'b1, 1'b0);
        rd0 = mk(22'h10, 32'h0, 1'b0, 1'b0);
        r1  = mk(22'h101, 32'h0, 1'b0, 1'b0);
        r2  = mk(22'h102, 32'h0, 1'b0, 1'b0);
        r3  = mk(22'h103, 32'h0, 1'b0, 1'b0);
        r4  = mk(22'h104, 32'h0, 1'b0, 1'b0);
        r5  = mk(22'h105, 32'h0, 1'b0, 1'b0);
        pw2 = mk(22'h200, 32'h55, 1'b1, 1'b0);
        npw = mk(22'h30, 32'h77, 1'b1, 1'b1);
        z34 = 34'd0;

        //          pvld  pd    rv    rpd                          prdy  gpvld gpd   cnt   rv    rpd
        vt[0]  = row(1'b1, pw1,  1'b0, z34,                        1'b1, 1'b1, pw1,  4'd0, 1'b0, z34);
        vt[1]  = row(1'b0, pw1,  1'b0, z34,                        1'b1, 1'b0, pw1,  4'd0, 1'b0, z34);
        vt[2]  = row(1'b1, rd0,  1'b0, z34,                        1'b1, 1'b1, rd0,  4'd0, 1'b0, z34);
        vt[3]  = row(1'b0, rd0,  1'b0, z34,                        1'b1, 1'b0, rd0,  4'd1, 1'b0, z34);
        vt[4]  = row(1'b0, rd0,  1'b1, {2'b00, 32'h1234_5678},     1'b1, 1'b0, rd0,  4'd0, 1'b1, {2'b00, 32'h1234_5678});
        vt[5]  = row(1'b0, rd0,  1'b0, z34,                        1'b1, 1'b0, rd0,  4'd0, 1'b0, z34);
        vt[6]  = row(1'b1, r1,   1'b0, z34,                        1'b1, 1'b1, r1,   4'd0, 1'b0, z34);
        vt[7]  = row(1'b1, r2,   1'b0, z34,                        1'b1, 1'b1, r2,   4'd1, 1'b0, z34);
        vt[8]  = row(1'b1, r3,   1'b0, z34,                        1'b1, 1'b1, r3,   4'd2, 1'b0, z34);
        vt[9]  = row(1'b1, r4,   1'b0, z34,                        1'b1, 1'b1, r4,   4'd3, 1'b0, z34);
        vt[10] = row(1'b1, r5,   1'b0, z34,                        1'b1, 1'b0, r5,   4'd4, 1'b0, z34);
        vt[11] = row(1'b1, pw2,  1'b0, z34,                        1'b0, 1'b0, r5,   4'd4, 1'b0, z34);
        vt[12] = row(1'b1, r1,   1'b0, z34,                        1'b0, 1'b0, r5,   4'd4, 1'b0, z34);
        vt[13] = row(1'b0, r1,   1'b1, {2'b00, 32'hA},             1'b0, 1'b1, r5,   4'd3, 1'b1, {2'b00, 32'hA});
        vt[14] = row(1'b0, r1,   1'b0, z34,                        1'b1, 1'b1, pw2,  4'd4, 1'b0, z34);
        vt[15] = row(1'b0, r1,   1'b0, z34,                        1'b1, 1'b0, pw2,  4'd4, 1'b0, z34);
        vt[16] = row(1'b0, r1,   1'b1, {2'b10, 32'hB},             1'b1, 1'b0, pw2,  4'd3, 1'b1, {2'b10, 32'hB});
        vt[17] = row(1'b0, r1,   1'b1, {2'b01, 32'hC},             1'b1, 1'b0, pw2,  4'd2, 1'b1, {2'b01, 32'hC});
        vt[18] = row(1'b0, r1,   1'b1, {2'b00, 32'hD},             1'b1, 1'b0, pw2,  4'd1, 1'b1, {2'b00, 32'hD});
        vt[19] = row(1'b0, r1,   1'b1, {2'b00, 32'hE},             1'b1, 1'b0, pw2,  4'd0, 1'b1, {2'b00, 32'hE});
        vt[20] = row(1'b1, rd0,  1'b0, z34,                        1'b1, 1'b1, rd0,  4'd0, 1'b0, z34);
        vt[21] = row(1'b0, rd0,  1'b0, z34,                        1'b1, 1'b0, rd0,  4'd1, 1'b0, z34);
        vt[22] = row(1'b1, r2,   1'b0, z34,                        1'b1, 1'b1, r2,   4'd1, 1'b0, z34);
        vt[23] = row(1'b0, r2,   1'b1, {2'b00, 32'hF},             1'b1, 1'b0, r2,   4'd1, 1'b1, {2'b00, 32'hF});
        vt[24] = row(1'b0, r2,   1'b1, {2'b00, 32'h10},            1'b1, 1'b0, r2,   4'd0, 1'b1, {2'b00, 32'h10});
        vt[25] = row(1'b0, r2,   1'b0, z34,                        1'b1, 1'b0, r2,   4'd0, 1'b0, z34);

        // Reset state.
        rst = 1'b1; req_pvld = 1'b0; req_pd = 63'd0; g_prdy = 1'b1;
        r_valid = 1'b0; r_pd = 34'd0;
        step();
        step();
        chk("rst_prdy", 64'(req_prdy), 64'd1);
        chk("rst_gpvld", 64'(g_pvld), 64'd0);
        chk("rst_gpd", 64'(g_pd), 64'd0);
        chk("rst_rv", 64'(o_valid), 64'd0);
        chk("rst_rpd", 64'(o_pd), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_terr", 64'(terr), 64'd0);
        chk("rst_stray", 64'(stray), 64'd0);
        rst = 1'b0;

        // Table-driven cycles.
        for (int i = 0; i < 26; i++) begin
            req_pvld = vt[i].pvld; req_pd = vt[i].pd;
            r_valid = vt[i].rv; r_pd = vt[i].rpd;
            step();
            chk($sformatf("v%0d_prdy", i), 64'(req_prdy), 64'(vt[i].e_prdy));
            chk($sformatf("v%0d_gpvld", i), 64'(g_pvld), 64'(vt[i].e_gpvld));
            if (vt[i].e_gpvld) chk($sformatf("v%0d_gpd", i), 64'(g_pd), 64'(vt[i].e_gpd));
            chk($sformatf("v%0d_cnt", i), 64'(cnt), 64'(vt[i].e_cnt));
            chk($sformatf("v%0d_rv", i), 64'(o_valid), 64'(vt[i].e_rv));
            if (vt[i].e_rv) chk($sformatf("v%0d_rpd", i), 64'(o_pd), 64'(vt[i].e_rpd));
            chk($sformatf("v%0d_terr", i), 64'(terr), 64'd0);
            chk($sformatf("v%0d_stray", i), 64'(stray), 64'd0);
        end
        req_pvld = 1'b0; r_valid = 1'b0;

        // Timeout on a non-posted write, then a late response becomes stray.
        req_pvld = 1'b1; req_pd = npw;
        step();
        chk("to_gpvld", 64'(g_pvld), 64'd1);
        req_pvld = 1'b0;
        step();
        chk("to_cnt1", 64'(cnt), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (o_valid || terr) seen = 1'b1;
        end
        chk("to_early", 64'(seen), 64'd0);
        step();
        chk("to_rv", 64'(o_valid), 64'd1);
        chk("to_rpd", 64'(o_pd), 64'({1'b1, 1'b1, 32'h0}));
        chk("to_terr", 64'(terr), 64'd1);
        chk("to_cnt0", 64'(cnt), 64'd0);
        chk("to_stray0", 64'(stray), 64'd0);
        r_valid = 1'b1; r_pd = {2'b10, 32'h99};
        step();
        r_valid = 1'b0;
        chk("late_stray", 64'(stray), 64'd1);
        chk("late_rv", 64'(o_valid), 64'd0);
        chk("late_terr", 64'(terr), 64'd0);

        // Real response in the cycle the timer reaches TIMEOUT-1.
        req_pvld = 1'b1; req_pd = rd0;
        step();
        req_pvld = 1'b0;
        step();
        chk("race_cnt1", 64'(cnt), 64'd1);
        for (int k = 0; k < 15; k++) step();
        r_valid = 1'b1; r_pd = {2'b00, 32'hCAFE};
        step();
        r_valid = 1'b0;
        chk("race_rv", 64'(o_valid), 64'd1);
        chk("race_rpd", 64'(o_pd), 64'({2'b00, 32'hCAFE}));
        chk("race_terr", 64'(terr), 64'd0);
        chk("race_cnt0", 64'(cnt), 64'd0);
        step();
        chk("race_terr2", 64'(terr), 64'd0);
        chk("race_rv2", 64'(o_valid), 64'd0);

        // Reset with two outstanding and a full FIFO.
        req_pvld = 1'b1; req_pd = r1;
        step();
        req_pd = r2;
        step();
        req_pd = r3;
        step();
        g_prdy = 1'b0; req_pd = r4;
        step();
        req_pvld = 1'b0;
        chk("pre_cnt", 64'(cnt), 64'd2);
        chk("pre_prdy", 64'(req_prdy), 64'd0);
        rst = 1'b1; r_valid = 1'b1; r_pd = {2'b00, 32'h1};
        step();
        chk("mr_prdy", 64'(req_prdy), 64'd1);
        chk("mr_gpvld", 64'(g_pvld), 64'd0);
        chk("mr_gpd", 64'(g_pd), 64'd0);
        chk("mr_rv", 64'(o_valid), 64'd0);
        chk("mr_rpd", 64'(o_pd), 64'd0);
        chk("mr_cnt", 64'(cnt), 64'd0);
        chk("mr_terr", 64'(terr), 64'd0);
        chk("mr_stray", 64'(stray), 64'd0);
        rst = 1'b0; g_prdy = 1'b1;
        step();
        r_valid = 1'b0;
        chk("mr_post_rv", 64'(o_valid), 64'd0);
        chk("mr_post_stray", 64'(stray), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (o_valid || terr || g_pvld) seen = 1'b1;
        end
        chk("mr_quiet", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
